vga_sync_gen: RTL and testbench

VGA raster timing generator for the 640x480@60 Hz display path. It produces the pixel coordinates (iVGA_X/iVGA_Y) that feed the on-screen overlay renderers such as the score-string display. It also produces the sync and blank strobes for the DAC, delayed by a programmable number of cycles so they line up with the renderers' registered RGB output. It also emits a one-cycle frame-start pulse and a free-running frame counter for frame-synchronous game logic.

---
 rtl/vga_sync_gen.sv | 129 ++++++++++++
 tb/tb_vga_sync_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel coordinates, sync/blank strobes with a
// programmable DAC alignment delay, frame-start pulse and frame counter.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic       oActive,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_n,
  output logic       oFrame_Start,
  output logic [7:0] oFrame_Cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HAct       = 10'(H_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0] VAct       = 10'(V_ACTIVE);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       h_last, v_last;
  logic       active, hs_raw, vs_raw, frame_start;

  logic [9:0] x_q, y_q;
  logic       active_q, frame_start_q;
  logic [7:0] frame_cnt_q;
  logic       hs_q, vs_q, blank_n_q;

  always_comb begin
    h_last      = (h_cnt_q == HLast);
    v_last      = (v_cnt_q == VLast);
    h_cnt_d     = h_last ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d     = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
    end
    active      = (h_cnt_q < HAct) && (v_cnt_q < VAct);
    hs_raw      = !((h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd));
    vs_raw      = !((v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd));
    frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 1: registered decode of the current counter position.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
    end else begin
      x_q           <= active ? h_cnt_q : 10'd0;
      y_q           <= active ? v_cnt_q : 10'd0;
      active_q      <= active;
      frame_start_q <= frame_start;
      frame_cnt_q   <= frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;
      hs_q          <= hs_raw;
      vs_q          <= vs_raw;
      blank_n_q     <= active;
    end
  end

  assign oVGA_X       = x_q;
  assign oVGA_Y       = y_q;
  assign oActive      = active_q;
  assign oFrame_Start = frame_start_q;
  assign oFrame_Cnt   = frame_cnt_q;

  // DAC strobes get PIPE_DELAY extra cycles to match the renderers' RGB registers.
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign oVGA_HS      = hs_q;
    assign oVGA_VS      = vs_q;
    assign oVGA_BLANK_n = blank_n_q;
  end else begin : g_delay
    localparam int unsigned PipeW = PIPE_DELAY;

    logic [PipeW-1:0] hs_pipe_q, vs_pipe_q, blank_pipe_q;

    // Bit 0 holds the newest sample; reset flushes every stage to idle.
    always_ff @(posedge iVGA_CLK) begin
      if (!iRST_n) begin
        hs_pipe_q    <= '1;
        vs_pipe_q    <= '1;
        blank_pipe_q <= '0;
      end else begin
        hs_pipe_q    <= PipeW'({hs_pipe_q, hs_q});
        vs_pipe_q    <= PipeW'({vs_pipe_q, vs_q});
        blank_pipe_q <= PipeW'({blank_pipe_q, blank_n_q});
      end
    end

    assign oVGA_HS      = hs_pipe_q[PipeW-1];
    assign oVGA_VS      = vs_pipe_q[PipeW-1];
    assign oVGA_BLANK_n = blank_pipe_q[PipeW-1];
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: arithmetic raster model checked every cycle on three
// instances (two shrunk timings, one default), plus literal timing pins.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int k = 0;
  bit armed = 1'b0;

  // Instance A: small raster 15x8 (frame 120), PIPE_DELAY 2.
  logic [9:0] xa, ya;
  logic acta, hsa, vsa, bla, fsa;
  logic [7:0] fca;
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIPE_DELAY(2)
  ) dut_a (
    .iVGA_CLK(clk), .iRST_n(rst_n), .oVGA_X(xa), .oVGA_Y(ya), .oActive(acta),
    .oVGA_HS(hsa), .oVGA_VS(vsa), .oVGA_BLANK_n(bla), .oFrame_Start(fsa), .oFrame_Cnt(fca)
  );

  // Instance B: small raster 11x7, PIPE_DELAY 0.
  logic [9:0] xb, yb;
  logic actb, hsb, vsb, blb, fsb;
  logic [7:0] fcb;
  vga_sync_gen #(
    .H_ACTIVE(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(3),
    .V_ACTIVE(3), .V_FRONT(2), .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(0)
  ) dut_b (
    .iVGA_CLK(clk), .iRST_n(rst_n), .oVGA_X(xb), .oVGA_Y(yb), .oActive(actb),
    .oVGA_HS(hsb), .oVGA_VS(vsb), .oVGA_BLANK_n(blb), .oFrame_Start(fsb), .oFrame_Cnt(fcb)
  );

  // Instance C: default 640x480 timing.
  logic [9:0] xc, yc;
  logic actc, hsc, vsc, blc, fsc;
  logic [7:0] fcc;
  vga_sync_gen dut_c (
    .iVGA_CLK(clk), .iRST_n(rst_n), .oVGA_X(xc), .oVGA_Y(yc), .oActive(actc),
    .oVGA_HS(hsc), .oVGA_VS(vsc), .oVGA_BLANK_n(blc), .oFrame_Start(fsc), .oFrame_Cnt(fcc)
  );

  // k = number of edges with reset released since the last reset edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      k     <= 0;
      armed <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d (k=%0d)", nm, act, exp, k);
    end
  endtask

  // Outputs after k released edges: stage-1 shows raster position k-1, the
  // strobes show position k-1-d, anything before release shows idle values.
  function automatic void model(input int ha, hf, hs, hb, va, vf, vs, vb, d, kk,
                                output logic [9:0] x, y, output logic act, hso, vso, bl, fs,
                                output logic [7:0] fc);
    int ht, vt, ft, p, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    ft = ht * vt;
    x = 0; y = 0; act = 0; hso = 1; vso = 1; bl = 0; fs = 0; fc = 0;
    if (kk >= 1) begin
      p   = (kk - 1) % ft;
      h   = p % ht;
      v   = p / ht;
      act = (h < ha) && (v < va);
      x   = act ? 10'(h) : 10'd0;
      y   = act ? 10'(v) : 10'd0;
      fs  = (p == 0);
      fc  = 8'((((kk - 1) / ft) + 1) % 256);
      p   = kk - 1 - d;
      if (p >= 0) begin
        p   = p % ft;
        h   = p % ht;
        v   = p / ht;
        hso = !((h >= ha + hf) && (h < ha + hf + hs));
        vso = !((v >= va + vf) && (v < va + vf + vs));
        bl  = (h < ha) && (v < va);
      end
    end
  endfunction

  logic [9:0] ex, ey;
  logic ea, eh, ev, eb, ef;
  logic [7:0] efc;

  always @(negedge clk) begin
    if (armed) begin
      model(8, 2, 3, 2, 4, 1, 2, 1, 2, k, ex, ey, ea, eh, ev, eb, ef, efc);
      chk("a_x", xa, ex);   chk("a_y", ya, ey);   chk("a_act", acta, ea);
      chk("a_hs", hsa, eh); chk("a_vs", vsa, ev); chk("a_blank", bla, eb);
      chk("a_fs", fsa, ef); chk("a_fcnt", fca, efc);
      model(5, 1, 2, 3, 3, 2, 1, 1, 0, k, ex, ey, ea, eh, ev, eb, ef, efc);
      chk("b_x", xb, ex);   chk("b_y", yb, ey);   chk("b_act", actb, ea);
      chk("b_hs", hsb, eh); chk("b_vs", vsb, ev); chk("b_blank", blb, eb);
      chk("b_fs", fsb, ef); chk("b_fcnt", fcb, efc);
      model(640, 16, 96, 48, 480, 10, 2, 33, 2, k, ex, ey, ea, eh, ev, eb, ef, efc);
      chk("c_x", xc, ex);   chk("c_y", yc, ey);   chk("c_act", actc, ea);
      chk("c_hs", hsc, eh); chk("c_vs", vsc, ev); chk("c_blank", blc, eb);
      chk("c_fs", fsc, ef); chk("c_fcnt", fcc, efc);
    end
  end

  task automatic wait_k(input int target);
    while (k < target) @(negedge clk);
  endtask

  initial begin
    int hs_low, hs_fall, vs_low, last_fs, ymax;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_x", xa, 0);        chk("rst_y", ya, 0);    chk("rst_act", acta, 0);
    chk("rst_hs", hsa, 1);      chk("rst_vs", vsa, 1);  chk("rst_blank", bla, 0);
    chk("rst_fs", fsa, 0);      chk("rst_fcnt", fca, 0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_k", k, 1);
    chk("first_act", actc, 1);  chk("first_fs", fsc, 1);
    chk("first_fcnt", fcc, 1);  chk("first_x", xc, 0);

    // Default raster, first line: HS fall position/width and X wrap.
    hs_low = 0;
    hs_fall = -1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (hsc == 1'b0) begin
        hs_low++;
        if (hs_fall < 0) hs_fall = k;
      end
      if (k == 640) begin
        chk("x_639", xc, 639);
        chk("act_at_639", actc, 1);
      end
      if (k == 641) begin
        chk("x_wrap", xc, 0);
        chk("act_fall", actc, 0);
      end
    end
    chk("hs_fall_k", hs_fall, 659);
    chk("hs_width", hs_low, 96);

    // Small raster A: three frames of VS width, frame period, Y range.
    vs_low = 0;
    last_fs = -1;
    ymax = 0;
    for (int i = 0; i < 360; i++) begin
      @(negedge clk);
      if (vsa == 1'b0) vs_low++;
      if (int'(ya) > ymax) ymax = int'(ya);
      if (fsa) begin
        if (last_fs >= 0) chk("fs_period", k - last_fs, 120);
        last_fs = k;
      end
    end
    chk("vs_low_3frames", vs_low, 90);
    chk("y_max", ymax, 3);

    // Frame counter wrap on the 256th pulse of raster A.
    wait_k(255 * 120);
    chk("fcnt_255", fca, 255);
    @(negedge clk);
    chk("fcnt_wrap", fca, 0);
    chk("fcnt_wrap_fs", fsa, 1);

    // Reset while A's pins sit inside both HS and VS.
    while (k % 120 != 88) @(negedge clk);
    chk("mid_hs_low", hsa, 0);
    chk("mid_vs_low", vsa, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_hs", hsa, 1);
    chk("mid_rst_vs", vsa, 1);
    chk("mid_rst_blank", bla, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_fs", fsa, 1);
    chk("mid_rel_fcnt", fca, 1);

    // Random reset pulses at random points of the raster.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 300)) @(negedge clk);
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (400) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
